dsc_mul_ctrl: RTL and testbench

Sequencer for the serial deterministic stochastic-computing multiplier. It takes one operand set per job through a valid/ready handshake and holds the operands on the datapath. It clears the datapath, enables it until the final stochastic-number generator's counter overflow (`ov`) marks the end of the run, then captures the product count and returns it through a second valid/ready handshake. It sits between the job source and one `dsc_mul`-style datapath instance, and guards against a missing overflow with a timeout and an error flag.

---
 rtl/dsc_mul_ctrl.sv | 144 ++++++++++++++
 tb/tb_dsc_mul_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_ctrl.sv
// Job sequencer for the serial deterministic stochastic-computing multiplier:
// accepts an operand set, clears and runs the datapath until overflow or timeout, returns the product count.
module dsc_mul_ctrl #(
  parameter int SNG_WIDTH  = 8,
  parameter int NUM_INPUTS = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TMO_SLACK  = 4,
  localparam int P = NUM_INPUTS * SNG_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [P-1:0] in_ops_i,
  input  logic         abort_i,
  output logic [P-1:0] dp_ops_o,
  output logic         dp_en_o,
  output logic         dp_rst_o,
  input  logic [P-1:0] dp_z_i,
  input  logic         dp_ov_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [P-1:0] out_z_o,
  output logic         out_err_o,
  output logic         busy_o
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  // One bit wider than the run length so the timeout limit is reachable without wrapping.
  localparam logic [P:0] TMO_LIMIT = {1'b1, {P{1'b0}}} + (P+1)'(TMO_SLACK);

  typedef enum logic [2:0] {IDLE, CLR, RUN, CAP, HOLD, ABRT} state_e;

  state_e        state_q;
  logic [CW-1:0] clr_q;
  logic [P:0]    tmo_q;
  logic [P:0]    tmo_inc;
  logic          err_q;
  logic [P-1:0]  dp_ops_q;
  logic          dp_en_q;
  logic          dp_rst_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [P-1:0]  out_z_q;
  logic          out_err_q;
  logic          busy_q;

  always_comb begin
    tmo_inc = tmo_q + {{P{1'b0}}, 1'b1};
  end

  // All outputs are registered alongside the state so they change only on the clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      clr_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      dp_ops_q    <= '0;
      dp_en_q     <= 1'b0;
      dp_rst_q    <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            dp_ops_q   <= in_ops_i;
            clr_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CLR;
          end
        end
        CLR: begin
          tmo_q <= '0;
          if (abort_i) begin
            state_q <= ABRT;
          end else if (clr_q == CLR_LAST) begin
            dp_rst_q <= 1'b0;
            dp_en_q  <= 1'b1;
            state_q  <= RUN;
          end else begin
            clr_q <= clr_q + CW'(1);
          end
        end
        RUN: begin
          tmo_q <= tmo_inc;
          // Overflow outranks a simultaneous timeout; abort outranks both.
          if (abort_i) begin
            dp_en_q  <= 1'b0;
            dp_rst_q <= 1'b1;
            state_q  <= ABRT;
          end else if (dp_ov_i) begin
            dp_en_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= CAP;
          end else if (tmo_inc == TMO_LIMIT) begin
            dp_en_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= CAP;
          end
        end
        CAP: begin
          out_z_q     <= dp_z_i;
          out_err_q   <= err_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            dp_rst_q    <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ABRT: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign dp_ops_o    = dp_ops_q;
  assign dp_en_o     = dp_en_q;
  assign dp_rst_o    = dp_rst_q;
  assign out_valid_o = out_valid_q;
  assign out_z_o     = out_z_q;
  assign out_err_o   = out_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Scoreboard bench for dsc_mul_ctrl with a behavioural two-operand SC datapath (2-bit operands, 16-cycle run).
module tb_dsc_mul_ctrl;

   localparam int SW    = 2;
   localparam int NI    = 2;
   localparam int P     = SW * NI;
   localparam int CLRC  = 2;
   localparam int SLACK = 4;

   typedef struct {
      logic [P-1:0] z;
      logic         err;
      int           acceptCycle;
      int           lat;
   } expEntry;

   logic         clk = 1'b0;
   logic         rstN = 1'b1;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [P-1:0] inOps = '0;
   logic         abortIn = 1'b0;
   logic [P-1:0] dpOps;
   logic         dpEn;
   logic         dpRst;
   logic [P-1:0] dpZ;
   logic         dpOv;
   logic         outValid;
   logic         outReady = 1'b1;
   logic [P-1:0] outZ;
   logic         outErr;
   logic         busy;

   logic [P-1:0] mC;
   logic [P-1:0] mZ;
   logic         ovEnable = 1'b1;

   int checkCount = 0;
   int errorCount = 0;
   int cycleCnt = 0;
   int enTotal = 0;
   int rstBusyTotal = 0;
   int enSnap = 0;
   int rstSnap = 0;
   int lastOutHs = 0;
   int lastAccept = 0;
   logic prevValid = 1'b0;
   expEntry expQ[$];

   dsc_mul_ctrl #(
      .SNG_WIDTH(SW),
      .NUM_INPUTS(NI),
      .CLR_CYCLES(CLRC),
      .TMO_SLACK(SLACK)
   ) dut (
      .clk_i(clk),
      .rst_ni(rstN),
      .in_valid_i(inValid),
      .in_ready_o(inReady),
      .in_ops_i(inOps),
      .abort_i(abortIn),
      .dp_ops_o(dpOps),
      .dp_en_o(dpEn),
      .dp_rst_o(dpRst),
      .dp_z_i(dpZ),
      .dp_ov_i(dpOv),
      .out_valid_o(outValid),
      .out_ready_i(outReady),
      .out_z_o(outZ),
      .out_err_o(outErr),
      .busy_o(busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Edge counter used to time accepts and result arrival.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Behavioural datapath: operand 0 uses the low counter bits (fastest generator),
   // operand 1 the high bits; overflow is flagged during the last enabled cycle of the run.
   always @(posedge clk) begin
      if (dpRst) begin
         mC <= '0;
         mZ <= '0;
      end else if (dpEn) begin
         mC <= mC + 1'b1;
         if ((mC[SW-1:0] < dpOps[SW-1:0]) && (mC[P-1:SW] < dpOps[P-1:SW])) mZ <= mZ + 1'b1;
      end
   end
   assign dpZ  = mZ;
   assign dpOv = ovEnable && dpEn && (mC == {P{1'b1}});

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Reference product: count cycles where every generator bit is high over the run length.
   function automatic logic [P-1:0] refProduct(input logic [P-1:0] ops, input int cycles);
      logic [P-1:0] z;
      logic [P-1:0] c;
      z = '0;
      for (int k = 0; k < cycles; k++) begin
         c = P'(k);
         if ((c[SW-1:0] < ops[SW-1:0]) && (c[P-1:SW] < ops[P-1:SW])) z = z + 1'b1;
      end
      return z;
   endfunction

   // Monitor: enable/clear cycle counting, result latency, scoreboard pop on output handshake.
   always @(negedge clk) begin
      if (rstN) begin
         if (dpEn) enTotal++;
         if (dpRst && busy) rstBusyTotal++;
         if (outValid && !prevValid) begin
            if (expQ.size() == 0) checkOutput("unexpValid", 1, 0);
            else checkOutput("latency", cycleCnt - expQ[0].acceptCycle, expQ[0].lat);
         end
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpResult", 1, 0);
            end else begin
               expEntry e;
               e = expQ.pop_front();
               checkOutput("outZ", outZ, e.z);
               checkOutput("outErr", outErr, e.err);
            end
            lastOutHs = cycleCnt + 1;
         end
         prevValid = outValid;
      end else begin
         prevValid = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [P-1:0] ops, input logic ovOn);
      int guard;
      expEntry e;
      guard = 0;
      ovEnable = ovOn;
      @(negedge clk);
      inOps = ops;
      inValid = 1'b1;
      while (!inReady && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!inReady) begin
         checkOutput("acceptTimeout", 0, 1);
         inValid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      lastAccept = cycleCnt;
      e.z = refProduct(ops, ovOn ? (1 << P) : (1 << P) + SLACK);
      e.err = !ovOn;
      e.acceptCycle = cycleCnt;
      e.lat = CLRC + (ovOn ? (1 << P) : (1 << P) + SLACK) + 1;
      expQ.push_back(e);
      enSnap = enTotal;
      rstSnap = rstBusyTotal;
      checkOutput("dpOps", dpOps, ops);
   endtask

   task automatic waitResult();
      int guard;
      guard = 0;
      while (expQ.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (expQ.size() != 0) begin
         checkOutput("resultTimeout", expQ.size(), 0);
         expQ.delete();
      end
   endtask

   task automatic waitEnable();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!dpEn && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("enableSeen", dpEn, 1);
   endtask

   initial begin
      logic [P-1:0] jobs[6];
      logic [P-1:0] heldZ;
      int guard;
      jobs = '{4'hE, 4'h5, 4'hF, 4'h0, 4'h3, 4'h9};

      $display("[TB] reset");
      #1 rstN = 1'b0;
      #1;
      checkOutput("rstInReady", inReady, 1);
      checkOutput("rstDpRst", dpRst, 1);
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idleInReady", inReady, 1);
      checkOutput("idleDpRst", dpRst, 1);
      checkOutput("idleDpEn", dpEn, 0);
      checkOutput("idleOutValid", outValid, 0);
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleOutZ", outZ, 0);
      checkOutput("idleOutErr", outErr, 0);
      checkOutput("idleDpOps", dpOps, 0);

      $display("[TB] nominal jobs");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(jobs[i], 1'b1);
         waitResult();
         checkOutput("enCycles", enTotal - enSnap, 1 << P);
         checkOutput("clrCycles", rstBusyTotal - rstSnap, CLRC);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(P'($urandom_range(0, (1 << P) - 1)), 1'b1);
         waitResult();
      end

      $display("[TB] timeout job");
      applyStimulus(4'h6, 1'b0);
      waitResult();
      checkOutput("tmoEnCycles", enTotal - enSnap, (1 << P) + SLACK);

      $display("[TB] held result");
      outReady = 1'b0;
      applyStimulus(4'hB, 1'b1);
      heldZ = refProduct(4'hB, 1 << P);
      guard = 0;
      while (!outValid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 10; i++) begin
         inValid = 1'b1;
         inOps = 4'h7;
         checkOutput("holdValid", outValid, 1);
         checkOutput("holdInReady", inReady, 0);
         checkOutput("holdOutZ", outZ, heldZ);
         @(negedge clk);
      end
      @(posedge clk);
      #1 outReady = 1'b1;
      applyStimulus(4'h7, 1'b1);
      checkOutput("acceptGap", lastAccept - lastOutHs, 1);
      waitResult();

      $display("[TB] abort");
      applyStimulus(4'hE, 1'b1);
      waitEnable();
      repeat (4) @(negedge clk);
      abortIn = 1'b1;
      @(posedge clk);
      #1 abortIn = 1'b0;
      @(negedge clk);
      expQ.delete();
      checkOutput("abrtDpEn", dpEn, 0);
      checkOutput("abrtDpRst", dpRst, 1);
      checkOutput("abrtBusy", busy, 1);
      @(negedge clk);
      checkOutput("abrtIdleBusy", busy, 0);
      checkOutput("abrtIdleReady", inReady, 1);
      checkOutput("abrtEnCycles", enTotal - enSnap, 5);
      checkOutput("abrtRstCycles", rstBusyTotal - rstSnap, CLRC + 1);
      repeat (30) @(negedge clk);
      checkOutput("abrtNoValid", outValid, 0);

      $display("[TB] reset mid-run");
      applyStimulus(4'hD, 1'b1);
      waitEnable();
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      expQ.delete();
      checkOutput("midRstInReady", inReady, 1);
      checkOutput("midRstDpRst", dpRst, 1);
      checkOutput("midRstDpEn", dpEn, 0);
      checkOutput("midRstOutValid", outValid, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstDpOps", dpOps, 0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(4'hA, 1'b1);
      waitResult();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Hard stop in case the main sequence stalls.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
